gate_bist_ctrl: RTL

//  Synthesizable self-test controller: the driving/checking end of a gate-under-test.
//  - On start, sweeps every input pattern onto a small combinational gate.
//  - Samples the gate's output for each pattern and compares it to an expected truth table.
//  - Reports pass/fail, mismatch count and the first failing pattern.
//  - Sits beside the basic-gate blocks; replaces hand-written stimulus on silicon/FPGA.

---
 rtl/gate_bist_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: self-test controller that sweeps every input pattern onto a small gate and checks its response.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   level, sampled only while idle
//   loop_i         in   (GATE_BIST_LOOP_EN only) restart the sweep straight from DONE
//   pat_o          out  pattern driven onto the gate inputs
//   resp_i         in   gate output, sampled once per pattern
//   busy           out  high while a sweep (including its DONE cycle) is in progress
//   done           out  one-cycle pulse at the end of a sweep
//   pass           out  1 when the last sweep had no mismatch
//   fail_cnt       out  mismatches in the last sweep
//   first_fail_pat out  first mismatching pattern, 0 if none
//
// Build option: define GATE_BIST_LOOP_EN to add loop_i and continuous sweeping.
module gate_bist_ctrl #(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 1,
    parameter logic [2**N_IN-1:0]    EXP_TT = 4'b1110
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef GATE_BIST_LOOP_EN
    input  logic            loop_i,
`endif
    output logic [N_IN-1:0] pat_o,
    input  logic            resp_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] first_fail_pat
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic            miss;
    logic            again;

    assign miss = resp_i != EXP_TT[idx];
`ifdef GATE_BIST_LOOP_EN
    assign again = loop_i;
`else
    assign again = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            pat_o          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_pat <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state          <= APPLY;
                    idx            <= '0;
                    pat_o          <= '0;
                    fail_cnt       <= '0;
                    first_fail_pat <= '0;
                    pass           <= 1'b0;
                    busy           <= 1'b1;
                end
                APPLY: begin
                    state <= SETTLE == 0 ? SAMPLE : WAIT;
                    cnt   <= CW'(SETTLE);
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (miss) begin
                        fail_cnt <= fail_cnt + 1'b1;
                        if (fail_cnt == '0) first_fail_pat <= idx;
                    end
                    if (&idx) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pat_o <= '0;
                        // fail_cnt has not yet absorbed this pattern's miss
                        pass  <= fail_cnt == '0 && !miss;
                    end else begin
                        state <= APPLY;
                        idx   <= idx + 1'b1;
                        pat_o <= idx + 1'b1;
                    end
                end
                DONE: if (again) begin
                    // looping restart keeps pass from the sweep just finished
                    state          <= APPLY;
                    idx            <= '0;
                    pat_o          <= '0;
                    fail_cnt       <= '0;
                    first_fail_pat <= '0;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
